// File: rtl/fir_poly_decim.sv
// Polyphase decimating FIR: per-phase delay lines, one time-multiplexed MAC with a
// registered multiplier, valid/ready input, pulsed output, runtime coefficient writes.
module fir_poly_decim #(
    parameter int unsigned M            = 20,
    parameter int unsigned BANK_LEN     = 6,
    parameter int unsigned N_TAPS       = M * BANK_LEN,
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned TAP_WIDTH    = 16,
    parameter int unsigned OUTPUT_WIDTH = INPUT_WIDTH + TAP_WIDTH + $clog2(N_TAPS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [INPUT_WIDTH-1:0]     din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic signed [OUTPUT_WIDTH-1:0]    dout,
    output logic                              dout_valid,
    input  logic                              tap_wr_en,
    input  logic        [$clog2(N_TAPS)-1:0]  tap_wr_addr,
    input  logic signed [TAP_WIDTH-1:0]       tap_wr_data
);

    localparam int unsigned AW = $clog2(N_TAPS);
    localparam int unsigned PW = INPUT_WIDTH + TAP_WIDTH;
    localparam int unsigned FW = PW + $clog2(N_TAPS);
    localparam int unsigned QW = $clog2(M);
    localparam int unsigned MW = (BANK_LEN > 1) ? $clog2(BANK_LEN) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    if (N_TAPS != M * BANK_LEN) begin : g_bad_taps
        $error("fir_poly_decim: N_TAPS must equal M*BANK_LEN");
    end
    if (M < 2) begin : g_bad_m
        $error("fir_poly_decim: M must be at least 2");
    end

    logic        [1:0]             state;
    logic        [QW-1:0]          phase;
    logic        [MW-1:0]          mcnt;
    logic signed [INPUT_WIDTH-1:0] dly [M][BANK_LEN];
    logic signed [TAP_WIDTH-1:0]   coef [N_TAPS];
    logic signed [PW-1:0]          prod;
    logic signed [FW-1:0]          acc;
    logic signed [FW-1:0]          acc_sum;
    logic signed [OUTPUT_WIDTH-1:0] dout_next;

    logic                          accept;
    logic                          tap_ok;
    logic                          mac_last;
    logic        [AW-1:0]          mac_idx;
    logic signed [INPUT_WIDTH-1:0] cur_x;
    logic signed [TAP_WIDTH-1:0]   cur_h;

    assign din_ready = (state == IDLE);
    assign accept    = din_valid && din_ready;
    assign tap_ok    = tap_wr_en && (state == IDLE) && (int'(tap_wr_addr) < int'(N_TAPS));
    assign mac_last  = (mcnt == MW'(BANK_LEN - 1));

    // Branch q tap m uses coefficient h[M-1-q+m*M]
    always_comb begin
        int idx;
        idx     = int'(M) - 1 - int'(phase) + int'(mcnt) * int'(M);
        mac_idx = AW'(idx);
        cur_x   = dly[phase][mcnt];
        cur_h   = coef[mac_idx];
    end

    assign acc_sum = acc + FW'(prod);

    if (OUTPUT_WIDTH <= FW) begin : g_out_trunc
        // Dropping low bits of a two's-complement value rounds toward -inf
        assign dout_next = acc_sum[FW-1 -: OUTPUT_WIDTH];
    end else begin : g_out_ext
        assign dout_next = OUTPUT_WIDTH'(acc_sum);
    end

    // Coefficients have no reset: contents survive rst and come from configuration
    always_ff @(posedge clk) begin
        if (tap_ok) begin
            coef[tap_wr_addr] <= tap_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            mcnt       <= '0;
            acc        <= '0;
            prod       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int p = 0; p < int'(M); p++) begin
                for (int k = 0; k < int'(BANK_LEN); k++) begin
                    dly[p][k] <= '0;
                end
            end
        end else begin
            dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int p = 0; p < int'(M); p++) begin
                            if (QW'(p) == phase) begin
                                dly[p][0] <= din;
                                for (int k = 1; k < int'(BANK_LEN); k++) begin
                                    dly[p][k] <= dly[p][k-1];
                                end
                            end
                        end
                        mcnt  <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    prod <= PW'(cur_x) * PW'(cur_h);
                    // prod still holds the previous sample's last product on the first cycle
                    if (mcnt != '0) begin
                        acc <= acc_sum;
                    end
                    if (mac_last) begin
                        mcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    if (phase == QW'(M - 1)) begin
                        phase      <= '0;
                        dout       <= dout_next;
                        dout_valid <= 1'b1;
                        acc        <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                        acc   <= acc_sum;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_poly_decim.sv
// Directed bench for fir_poly_decim at M=4, BANK_LEN=3: impulse, DC, extremes,
// handshake timing, mid-MAC reset and coefficient-port rules.
module tb_fir_poly_decim;

    localparam int M  = 4;
    localparam int B  = 3;
    localparam int NT = 12;
    localparam int IW = 12;
    localparam int TW = 16;
    localparam int OW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [IW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic signed [OW-1:0] dout;
    logic                 dout_valid;
    logic                 tap_wr_en = 1'b0;
    logic        [3:0]    tap_wr_addr = '0;
    logic signed [TW-1:0] tap_wr_data = '0;

    fir_poly_decim #(
        .M            (M),
        .BANK_LEN     (B),
        .N_TAPS       (NT),
        .INPUT_WIDTH  (IW),
        .TAP_WIDTH    (TW),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .tap_wr_en   (tap_wr_en),
        .tap_wr_addr (tap_wr_addr),
        .tap_wr_data (tap_wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic signed [OW-1:0] outq [$];
    int                   outt [$];
    int                   acct [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Edge indices: posedge sees the pre-increment count, negedge must subtract one
    always @(posedge clk) if (din_valid && din_ready) acct.push_back(cyc);
    always @(negedge clk) if (dout_valid) begin
        outq.push_back(dout);
        outt.push_back(cyc - 1);
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        outq.delete();
        outt.delete();
        acct.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        tap_wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!din_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!din_ready) check_val("ready_timeout", 0, 1);
    endtask

    task automatic send(input int x, input bit wr, input int addr, input int data);
        wait_ready();
        din         = IW'(x);
        din_valid   = 1'b1;
        tap_wr_en   = wr;
        tap_wr_addr = 4'(addr);
        tap_wr_data = TW'(data);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        tap_wr_en = 1'b0;
    endtask

    task automatic pulse_tap(input int addr, input int data);
        @(negedge clk);
        tap_wr_en   = 1'b1;
        tap_wr_addr = 4'(addr);
        tap_wr_data = TW'(data);
        @(posedge clk);
        #1;
        tap_wr_en = 1'b0;
    endtask

    task automatic write_tap(input int addr, input int data);
        wait_ready();
        tap_wr_en   = 1'b1;
        tap_wr_addr = 4'(addr);
        tap_wr_data = TW'(data);
        @(posedge clk);
        #1;
        tap_wr_en = 1'b0;
    endtask

    task automatic load_ramp();
        for (int j = 0; j < NT; j++) write_tap(j, j + 1);
    endtask

    task automatic load_const(input int v);
        for (int j = 0; j < NT; j++) write_tap(j, v);
    endtask

    task automatic drain();
        repeat (B + 4) @(negedge clk);
    endtask

    task automatic check_four(input string tag, input longint e0, input longint e1,
                              input longint e2, input longint e3);
        longint exp [4];
        exp = '{e0, e1, e2, e3};
        check_val({tag, "_count"}, outq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_y%0d", tag, i),
                      (i < outq.size()) ? longint'(outq[i]) : longint'(32'hdead_beef), exp[i]);
        end
    endtask

    // Impulse through the filter; the first sample may carry a same-cycle h[3] write
    task automatic run_impulse(input bit with_rst, input bit wr, input int wr_data);
        if (with_rst) do_reset();
        send(1, wr, 3, wr_data);
        for (int i = 0; i < 15; i++) send(0, 0, 0, 0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_val("rst_dout", dout, 0);
        check_val("rst_dout_valid", dout_valid, 0);
        check_val("rst_din_ready", din_ready, 1);

        // 1. Impulse with h[j]=j+1
        load_ramp();
        run_impulse(1, 0, 0);
        check_four("impulse", 4, 8, 12, 0);

        // 2. DC
        load_const(1);
        do_reset();
        for (int i = 0; i < 16; i++) send(100, 0, 0, 0);
        drain();
        check_four("dc", 400, 800, 1200, 1200);

        // 3. Extremes: 12 products of 67108864
        load_const(-32768);
        do_reset();
        for (int i = 0; i < 16; i++) send(-2048, 0, 0, 0);
        drain();
        check_four("extreme", 268435456, 536870912, 805306368, 805306368);

        // 4. Handshake with din_valid held high
        do_reset();
        begin
            int k = 0;
            @(negedge clk);
            din       = IW'(7);
            din_valid = 1'b1;
            while (acct.size() < 8 && k < 200) begin
                @(negedge clk);
                k++;
            end
            din_valid = 1'b0;
            check_val("hs_accept_count", acct.size(), 8);
        end
        drain();
        for (int i = 0; i + 1 < acct.size(); i++) begin
            check_val($sformatf("hs_gap%0d", i), acct[i+1] - acct[i], B + 2);
        end
        check_val("hs_dout_count", outt.size(), 2);
        if (outt.size() >= 2 && acct.size() >= 4) begin
            check_val("hs_latency", outt[0] - acct[3], B + 1);
            check_val("hs_out_period", outt[1] - outt[0], M * (B + 2));
        end

        // 5. Reset during the MAC of phase 2, then impulse without another reset
        load_ramp();
        do_reset();
        send(5, 0, 0, 0);
        send(6, 0, 0, 0);
        send(7, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_din_ready", din_ready, 1);
        check_val("midrst_dout", dout, 0);
        repeat (B + 4) @(negedge clk);
        check_val("midrst_no_output", outq.size(), 0);
        clear_logs();
        run_impulse(0, 0, 0);
        check_four("midrst_impulse", 4, 8, 12, 0);

        // 6. Coefficient port: busy write and out-of-range address are dropped
        do_reset();
        send(0, 0, 0, 0);
        pulse_tap(3, 99);
        write_tap(12, 77);
        run_impulse(1, 0, 0);
        check_four("tap_ignored", 4, 8, 12, 0);
        write_tap(3, 99);
        run_impulse(1, 0, 0);
        check_four("tap_idle_wr", 99, 8, 12, 0);
        run_impulse(1, 1, 55);
        check_four("tap_same_cycle", 55, 8, 12, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_poly_decim.md
Name: fir_poly_decim

Overview:
Parametrised polyphase decimating FIR. It generalises the fixed 120-tap/M=20 bank to arbitrary M and BANK_LEN, and adds:
- an internal sequencer and a single time-multiplexed MAC;
- valid/ready input and valid output handshakes;
- a runtime coefficient write port;
- synchronous reset.

It sits between the ADC sample stream and the downstream FFT/decimation chain. It emits one output per M accepted inputs.

Parameters:
M, 20, decimation factor (>=2)
BANK_LEN, 6, taps per polyphase branch
N_TAPS, M*BANK_LEN, total taps (must equal M*BANK_LEN)
INPUT_WIDTH, 12, signed sample width
TAP_WIDTH, 16, signed coefficient width
OUTPUT_WIDTH, INPUT_WIDTH+TAP_WIDTH+$clog2(N_TAPS), signed output width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  INPUT_WIDTH  signed input sample
din_valid  in  1  din is valid
din_ready  out  1  block can accept din this cycle
dout  out  OUTPUT_WIDTH  signed filtered, decimated sample
dout_valid  out  1  one-cycle pulse, dout updated
tap_wr_en  in  1  coefficient write strobe
tap_wr_addr  in  $clog2(N_TAPS)  coefficient index j
tap_wr_data  in  TAP_WIDTH  signed coefficient h[j]

Behaviour:
- Function: y[n] = sum over j=0..N_TAPS-1 of h[j]*x[nM+M-1-j]. Samples x[k] with k<0 are 0.
- Phase counter q: 0..M-1, increments on each accepted sample, wraps M-1 -> 0.
- Delay lines: one per phase, each BANK_LEN deep, line[q][m] = x[i-mM]. On acceptance, only line[q] shifts; the new sample enters at m=0.
- Per sample, perform BANK_LEN MACs of h[M-1-q+mM]*line[q][m], for m=0..BANK_LEN-1, into one shared accumulator.
- FSM states:
  - IDLE: din_ready=1. Acceptance (din_valid&&din_ready) -> MAC, with counter m=0.
  - MAC: lasts BANK_LEN cycles. Each cycle issues one product into a registered multiplier and accumulates the previous product. -> DRAIN after BANK_LEN cycles.
  - DRAIN: 1 cycle. Accumulates the last product. -> IDLE.
- Output: leaving DRAIN with q==M-1, dout <= final sum, dout_valid=1 for exactly 1 cycle, and the accumulator clears in the same cycle.
- Latency: sample accepted at edge t gives dout_valid high after edge t+BANK_LEN+1.
- Throughput: at most one sample per BANK_LEN+2 cycles. din_ready is 0 in MAC and DRAIN.
- Arithmetic:
  - Products are full precision (INPUT_WIDTH+TAP_WIDTH).
  - The accumulator is full width, so there is no overflow.
  - If OUTPUT_WIDTH is less than full width, dout is the top OUTPUT_WIDTH bits, truncated toward -inf.
- Coefficients:
  - Writes are accepted only in IDLE; writes while busy are dropped.
  - tap_wr_addr>=N_TAPS is ignored.
  - A write in the same IDLE cycle as a sample acceptance is used by that sample's MACs.
  - Coefficients are 0 at configuration and are not cleared by rst.
- Reset: rst clears state to IDLE, q=0, all delay lines, accumulator, multiplier register, dout=0 and dout_valid=0.
  - rst overrides everything in the same cycle, including mid-MAC. The sample in progress is discarded.
  - din_ready=1 in the cycle after rst deasserts.
- din_valid while busy: no acceptance. Upstream holds the sample until din_ready.

Test Plan:
(M=4, BANK_LEN=3, N_TAPS=12, INPUT_WIDTH=12, TAP_WIDTH=16, OUTPUT_WIDTH=32)
1. Impulse: load h[j]=j+1, send x=1 then 15 zeros -> dout sequence 4, 8, 12, 0.
2. DC: all h=1, constant x=100 -> dout 400, 800, 1200, 1200, ...
3. Extremes: all h=-32768, x=-2048 steady -> steady dout 805306368, with no wrap.
4. Handshake: din_valid held high -> acceptances exactly 5 cycles apart; dout_valid every 20 cycles, 1 cycle wide, 4 cycles after the 4th acceptance edge.
5. Reset mid-op: rst during MAC of phase 2, then rerun the impulse test -> dout identical to scenario 1, with no spurious dout_valid.
6. Coefficient port: write h[3]=99 while busy and write addr 12 in IDLE -> both ignored; impulse still yields 4. Write h[3]=99 in IDLE -> impulse yields 99.
